// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: assembles a little-endian byte stream into
// 32-bit word writes from BASE_ADDR and holds the core in reset until the image is written.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module imem_loader #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned            DEPTH_BYTES = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     len_i,
  input  logic [DATA_WIDTH-1:0]     byte_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  output logic                      we_o,
  output logic [ADDR_WIDTH-1:0]     WA_o,
  output logic [4*DATA_WIDTH-1:0]   WD_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      cpu_rst_o,
  output logic [2:0]                state_o
);

  localparam logic [ADDR_WIDTH-1:0] MAX_WORDS = ADDR_WIDTH'(DEPTH_BYTES / 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  // Handshake: a byte moves on any rising edge where byte_valid_i && byte_ready_o;
  // byte_ready_o depends only on state, so it never combinationally follows byte_valid_i.

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_WIDTH-1:0]     r_len;
  logic [ADDR_WIDTH-1:0]     r_word_idx;
  logic [1:0]                r_byte_idx;
  logic [3*DATA_WIDTH-1:0]   r_word;
  logic                      r_we;
  logic [ADDR_WIDTH-1:0]     r_wa;
  logic [4*DATA_WIDTH-1:0]   r_wd;
  logic                      r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                r_sum;
`endif

  logic w_ready;
  logic w_xfer;
  logic w_last;
  logic w_start;

  assign w_ready = (r_state == S_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (r_state == S_CHECK)
`endif
                 ;
  assign w_xfer  = byte_valid_i && w_ready;
  assign w_start = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last  = (r_byte_idx == 2'd3) && (r_word_idx == (r_len - ADDR_WIDTH'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          if ((len_i == '0) || (len_i > MAX_WORDS)) w_next = S_DONE;
          else                                      w_next = S_LOAD;
        end
      end
      S_LOAD:  if (w_xfer && w_last) w_next = S_FLUSH;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_FLUSH: w_next = S_CHECK;
      S_CHECK: if (w_xfer) w_next = S_DONE;
`else
      S_FLUSH: w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_we       <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_len      <= len_i;
        r_err      <= (len_i > MAX_WORDS);
        r_word_idx <= '0;
        r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end else if (w_xfer && (r_state == S_LOAD)) begin
        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum      <= r_sum + 8'(byte_i);
`endif
        case (r_byte_idx)
          2'd0: r_word[DATA_WIDTH-1:0]              <= byte_i;
          2'd1: r_word[2*DATA_WIDTH-1:DATA_WIDTH]   <= byte_i;
          2'd2: r_word[3*DATA_WIDTH-1:2*DATA_WIDTH] <= byte_i;
          default: begin
            // Fourth byte bypasses the assembly register straight into the write data.
            r_wd       <= {byte_i, r_word};
            r_wa       <= BASE_ADDR + {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
            r_we       <= 1'b1;
            r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
          end
        endcase
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      else if (w_xfer) begin
        r_err <= (8'(byte_i) != r_sum);
      end
`endif
    end
  end

  assign byte_ready_o = w_ready;
  assign we_o         = r_we;
  assign WA_o         = r_wa;
  assign WD_o         = r_wd;
  assign busy_o       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;
  assign cpu_rst_o    = !((r_state == S_DONE) && !r_err);
  assign state_o      = r_state;

endmodule
